// File: rtl/mul_rr_scheduler.sv
// mul_rr_scheduler
//   Shares one external combinational W x W unsigned multiplier among N_REQ
//   requesters. A round-robin arbiter grants one operand pair at a time. The
//   granted operands are registered onto mul_a/mul_b. The 2W-bit product
//   returned on mul_o is captured one cycle later and presented on a
//   valid/ready response port, tagged with the requester index.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   req_valid  [N_REQ]      request present per requester
//   req_a      [N_REQ*W]    operand a, requester i at [i*W +: W]
//   req_b      [N_REQ*W]    operand b, requester i at [i*W +: W]
//   req_ready  [N_REQ]      one-hot grant (combinational), or all zero
//   mul_a      [W]          registered operand a to the multiplier
//   mul_b      [W]          registered operand b to the multiplier
//   mul_o      [2W]         product from the external multiplier
//   rsp_valid               result available
//   rsp_id     [clog2(N_REQ)] owner of the result
//   rsp_data   [2W]         full-width product
//   rsp_ready               consumer accepts the result
module mul_rr_scheduler #(
   parameter int N_REQ = 4,
   parameter int W     = 8,
   localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [N_REQ*W-1:0] req_a,
   input  logic [N_REQ*W-1:0] req_b,
   output logic [N_REQ-1:0]   req_ready,
   output logic [W-1:0]       mul_a,
   output logic [W-1:0]       mul_b,
   input  logic [2*W-1:0]     mul_o,
   output logic               rsp_valid,
   output logic [IW-1:0]      rsp_id,
   output logic [2*W-1:0]     rsp_data,
   input  logic               rsp_ready
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] cur_id;

   logic [IW-1:0] win;
   logic [IW-1:0] cand;
   logic [IW:0]   sum;
   logic          found;
   logic          grant_en;
   logic          fire;
   logic [W-1:0]  sel_a;
   logic [W-1:0]  sel_b;

   // Round-robin scan starting at ptr. The index wraps by a conditional
   // subtract rather than a modulo, so non-power-of-two N_REQ stays cheap.
   always_comb begin
      win   = ptr;
      cand  = '0;
      sum   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         sum = {1'b0, ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(N_REQ)) begin
            sum = sum - (IW+1)'(N_REQ);
         end
         cand = sum[IW-1:0];
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      sel_a = W'(req_a >> (int'(win) * W));
      sel_b = W'(req_b >> (int'(win) * W));
   end

   // Grants are only offered when the operand registers are free: in IDLE,
   // or in RESP when the current result is leaving this cycle.
   assign grant_en = !rst && ((state == S_IDLE) || ((state == S_RESP) && rsp_ready));
   assign fire     = grant_en && found;

   always_comb begin
      req_ready = '0;
      if (fire) begin
         req_ready[win] = 1'b1;
      end
   end

   assign rsp_valid = (state == S_RESP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         ptr      <= '0;
         cur_id   <= '0;
         mul_a    <= '0;
         mul_b    <= '0;
         rsp_id   <= '0;
         rsp_data <= '0;
      end else begin
         if (fire) begin
            mul_a  <= sel_a;
            mul_b  <= sel_b;
            cur_id <= win;
            ptr    <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (fire) begin
                  state <= S_BUSY;
               end
            end
            S_BUSY: begin
               rsp_data <= mul_o;
               rsp_id   <= cur_id;
               state    <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state <= fire ? S_BUSY : S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Directed bench for mul_rr_scheduler with an ideal multiplier on mul_o.
module tb_mul_rr_scheduler;

   localparam int N = 4;
   localparam int W = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  req_ready;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [15:0] mul_o;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_data;
   logic        rsp_ready;

   int checks   = 0;
   int failures = 0;
   int mdl_ptr  = 0;

   mul_rr_scheduler #(.N_REQ(N), .W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_o     (mul_o),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_ready (rsp_ready)
   );

   assign mul_o = 16'(mul_a) * 16'(mul_b);

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One grant/response round trip. Must start in IDLE, or in RESP with
   // rsp_ready high. Winner is predicted from mdl_ptr.
   task automatic txn(input logic [3:0] mask, input string tag);
      int win;
      logic [7:0] a;
      logic [7:0] b;
      win = -1;
      for (int k = 0; k < N; k++) begin
         if (win < 0 && mask[(mdl_ptr + k) % N]) win = (mdl_ptr + k) % N;
      end
      req_valid = mask;
      #1;
      check({tag, " grant"}, 32'(req_ready), 32'(4'b0001 << win));
      a = req_a[win*8 +: 8];
      b = req_b[win*8 +: 8];
      tick();
      // operands must already be latched, so disturb the winner's inputs
      req_a[win*8 +: 8] = 8'($urandom);
      req_b[win*8 +: 8] = 8'($urandom);
      check({tag, " busy valid"}, 32'(rsp_valid), 32'(0));
      check({tag, " busy ready"}, 32'(req_ready), 32'(0));
      tick();
      check({tag, " rsp valid"}, 32'(rsp_valid), 32'(1));
      check({tag, " rsp id"}, 32'(rsp_id), 32'(win));
      check($sformatf("%s data a=%0d b=%0d id=%0d", tag, a, b, win),
            32'(rsp_data), 32'(16'(a) * 16'(b)));
      mdl_ptr = (win + 1) % N;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [3:0]  exp_rdy [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      logic [7:0]  exp_a   [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2};
      logic [7:0]  exp_b   [6] = '{8'd3, 8'd19, 8'd35, 8'd51, 8'd3, 8'd19};
      logic [15:0] exp_d   [6] = '{16'd3, 16'd38, 16'd105, 16'd204, 16'd3, 16'd38};
      logic [1:0]  exp_id  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      logic [7:0]  vals    [7] = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd254, 8'd255};

      // reset with every requester asserting
      rst       = 1'b1;
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      req_a     = {8'd4, 8'd3, 8'd2, 8'd1};
      req_b     = {8'd51, 8'd35, 8'd19, 8'd3};
      repeat (3) begin
         tick();
         check("rst req_ready", 32'(req_ready), 32'(0));
         check("rst rsp_valid", 32'(rsp_valid), 32'(0));
      end
      check("rst mul_a", 32'(mul_a), 32'(0));
      check("rst mul_b", 32'(mul_b), 32'(0));
      check("rst rsp_data", 32'(rsp_data), 32'(0));
      check("rst rsp_id", 32'(rsp_id), 32'(0));
      rst = 1'b0;
      #1;

      // fairness: all valid, back-to-back through RESP->BUSY
      for (int g = 0; g < 6; g++) begin
         check("fair grant", 32'(req_ready), 32'(exp_rdy[g]));
         tick();
         check("fair mul_a", 32'(mul_a), 32'(exp_a[g]));
         check("fair mul_b", 32'(mul_b), 32'(exp_b[g]));
         check("fair busy valid", 32'(rsp_valid), 32'(0));
         tick();
         check("fair rsp valid", 32'(rsp_valid), 32'(1));
         check("fair rsp id", 32'(rsp_id), 32'(exp_id[g]));
         check("fair rsp data", 32'(rsp_data), 32'(exp_d[g]));
      end
      req_valid = 4'b0000;
      #1;
      check("drain ready", 32'(req_ready), 32'(0));
      tick();
      check("idle valid", 32'(rsp_valid), 32'(0));

      // single request from requester 2, then backpressure
      rsp_ready = 1'b0;
      req_valid = 4'b0100;
      req_a[23:16] = 8'd255;
      req_b[23:16] = 8'd255;
      #1;
      check("single grant", 32'(req_ready), 32'(4'b0100));
      tick();
      check("single mul_a", 32'(mul_a), 32'(255));
      req_valid = 4'b1001;
      tick();
      check("single valid", 32'(rsp_valid), 32'(1));
      check("single id", 32'(rsp_id), 32'(2));
      check("single data", 32'(rsp_data), 32'(16'hFE01));
      check("stall ready", 32'(req_ready), 32'(0));
      repeat (5) begin
         tick();
         check("stall valid", 32'(rsp_valid), 32'(1));
         check("stall id", 32'(rsp_id), 32'(2));
         check("stall data", 32'(rsp_data), 32'(16'hFE01));
         check("stall ready", 32'(req_ready), 32'(0));
      end
      rsp_ready = 1'b1;
      #1;
      check("unstall grant", 32'(req_ready), 32'(4'b1000));
      tick();
      req_valid = 4'b0001;
      check("unstall busy valid", 32'(rsp_valid), 32'(0));
      tick();
      check("unstall id", 32'(rsp_id), 32'(3));
      check("unstall data", 32'(rsp_data), 32'(204));
      check("wrap grant", 32'(req_ready), 32'(4'b0001));
      tick();

      // reset while BUSY
      rst = 1'b1;
      req_valid = 4'b0101;
      #1;
      check("midrst ready", 32'(req_ready), 32'(0));
      tick();
      check("midrst valid", 32'(rsp_valid), 32'(0));
      check("midrst data", 32'(rsp_data), 32'(0));
      rst = 1'b0;
      mdl_ptr = 0;
      txn(4'b0101, "postrst");

      // single requester wins every slot
      repeat (3) txn(4'b0010, "solo");

      // operand corner sweep on requester 1
      for (int i = 0; i < 7; i++) begin
         for (int j = 0; j < 7; j++) begin
            req_a[15:8] = vals[i];
            req_b[15:8] = vals[j];
            txn(4'b0010, "sweep");
         end
      end

      // random multi-requester traffic
      for (int n = 0; n < 200; n++) begin
         req_a = $urandom;
         req_b = $urandom;
         txn(4'($urandom_range(1, 15)), "rand");
      end

      req_valid = 4'b0000;
      tick();
      check("end idle", 32'(rsp_valid), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
